rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and a long-latency producer such as a D-cache miss return or a multi-cycle unit. Writeback always wins. Long-latency results wait in a small queue that drains on idle writeback cycles. The block drives the write-enable, register id and data that feed the register file's 4-to-16 write decoder. It also gives the hazard unit pending-write and starvation indications.

## Interface
- DEPTH, 2: queue entries for long-latency results; power of two, ≥2
- DATA_W, 16: register data width
- STARVE_LIMIT, 4: consecutive blocked cycles before `starve` asserts; ≥1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  writeback stage writes this cycle; never back-pressured
- wb_reg  in  4  writeback destination
- wb_data  in  DATA_W  writeback value
- ml_valid  in  1  long-latency result offered
- ml_reg  in  4  its destination
- ml_data  in  DATA_W  its value
- ml_ready  out  1  queue can accept; transfer on ml_valid & ml_ready
- rs_id, rt_id  in  4 each  source ids from decode
- pend_rs, pend_rt  out  1 each  a live queued write targets that source
- starve  out  1  hazard unit must bubble writeback next cycle
- rf_write_reg  out  1  write enable to the decoder
- rf_reg_id  out  4  decoder register id
- rf_wdata  out  DATA_W  write data

## Operation
- **Reset values.** All `rf_*` outputs are 0. `starve` is 0. The queue is empty, so `ml_ready` is 1. `pend_*` is 0.
- **Queue.** FIFO of {live, reg, data}.
  - `ml_ready` = (count < DEPTH). It is based on count only, so when full, a same-cycle pop does not re-open it.
  - An accepted entry is enqueued with live = 1.
- **Port selection, per cycle, registered into the `rf_*` outputs:**
  - wb_valid: the port takes {wb_reg, wb_data}. The write enable is 1 only if wb_reg ≠ 0.
  - Otherwise, a live head: pop it and write its {reg, data}. The write enable is 1 only if reg ≠ 0.
  - Otherwise: the write enable is 0. `rf_reg_id` and `rf_wdata` hold their previous values.
- **Dead head.** A head with live = 0 is popped in any cycle, whether or not wb_valid is high, and performs no write. At most one pop happens per cycle.
- **Squash (WAW).** When wb_valid is high and wb_reg ≠ 0, every queued entry with reg == wb_reg gets live = 0 at the edge. An ml entry accepted in the same cycle counts as newer and is not squashed.
- **R0.** Writes to R0 never reach the port. R0 entries are still accepted and popped like any other.
- **Pending flags.** `pend_rs` is combinational: 1 if any live entry has reg == rs_id and rs_id ≠ 0. `pend_rt` works the same way with rt_id.
- **Starvation counter.**
  - It increments each cycle that the head is live and wb_valid is high, saturating at STARVE_LIMIT.
  - It clears when the head is popped or the queue empties.
  - `starve` is registered and equals (counter == STARVE_LIMIT).
  - If writeback ignores `starve`, it still wins.
- **Reset mid-operation.** Queued entries are discarded and produce no write.

## Timing
- Writeback: wb_valid in cycle N gives `rf_write_reg` in cycle N+1, one cycle of latency.
- Long-latency: accepted at edge N, it is written at N+2 at the earliest (popped in N+1 if writeback is idle). There is no same-cycle bypass from `ml_*` to the port.
- `ml_ready`, `pend_*`: combinational from registered state plus `rs_id`/`rt_id`.
- Simultaneous accept and pop with count < DEPTH: count is unchanged.

## Structure
- **Shared package** (`rf_pkg`): REG_W = 4, R0 = 4'd0, and the default DATA_W. The queue entry struct also belongs there.
- **One sub-module,** `rf_wr_fifo`: circular FIFO with per-entry live bits.
  - Inputs: push, pop, a squash-match input, and query compare ports.
  - Outputs: head, count, and the hit flags.
- The arbiter top holds the selection logic, the output registers and the starvation counter. The existing write decoder is instantiated downstream, not inside this block.

## Test plan
- **Reset:** assert rst mid-traffic with two entries queued → next cycle all `rf_*` = 0, `ml_ready` = 1, `pend_*` = 0, and no queued write ever appears.
- **Writeback only:** wb_valid, reg 5, data 0x1234 in cycle N → cycle N+1 has `rf_write_reg` = 1, `rf_reg_id` = 5, `rf_wdata` = 0x1234.
- **Conflict and back-pressure:**
  - Stimulus: wb_valid held for 3 cycles. During them, ml writes are accepted to reg 7 (0xBEEF) and reg 8 (0xCAFE).
  - Expected: `ml_ready` = 0 after the second accept. Reg 7 is written 1 cycle after writeback first goes idle, and reg 8 the cycle after that, in order.
- **Squash:**
  - Stimulus: ml entry reg 9 = 0xAAAA is queued, then wb writes reg 9 = 0x5555. `rs_id` = 9 throughout.
  - Expected: only 0x5555 is written. `pend_rs` goes 1→0 after the wb edge. The dead entry pops with no write.
- **R0:** wb reg 0 and ml reg 0 → `rf_write_reg` stays 0, and the ml entry is accepted and popped.
- **Starve:** queue non-empty and wb_valid held for 4 cycles → `starve` = 1 after the 4th edge. Drop wb_valid → the entry drains and `starve` returns to 0 the following cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write-port arbiter and its queue.
//   REG_W      : register id width (16 architectural registers)
//   R0         : hard-wired zero register; writes to it never reach the port
//   DATA_W_DEF : default register data width
//   rf_tag_t   : per-entry queue tag {live, register id}. Entry data is kept in
//                a parallel array so its width can follow the DATA_W parameter.
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] R0 = 4'd0;
    localparam int DATA_W_DEF = 16;

    typedef struct packed {
        logic             live;
        logic [REG_W-1:0] rid;
    } rf_tag_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// -----------------------------------------------------------------------------
// rf_wr_fifo
// Circular FIFO of long-latency register writes with a live bit per entry.
// A live bit is cleared when its entry is popped or squashed by a newer write to
// the same register, so "live" also implies "occupied" for the query ports.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   push, push_reg/data  enqueue a new live entry
//   pop                  retire the head entry
//   squash_en/reg        kill every queued entry targeting squash_reg
//   query_a/b            register ids compared against live entries
//   head_live/reg/data   head entry contents
//   count                number of occupied slots (live or dead)
//   hit_a/b              a live entry targets query_a / query_b
// -----------------------------------------------------------------------------
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = DATA_W_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [REG_W-1:0]  push_reg,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              squash_en,
    input  logic [REG_W-1:0]  squash_reg,
    input  logic [REG_W-1:0]  query_a,
    input  logic [REG_W-1:0]  query_b,
    output logic              head_live,
    output logic [REG_W-1:0]  head_reg,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              hit_a,
    output logic              hit_b
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    rf_tag_t           tag_r  [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;

    assign head_live = tag_r[rd_ptr_r].live;
    assign head_reg  = tag_r[rd_ptr_r].rid;
    assign head_data = data_r[rd_ptr_r];
    assign count     = count_r;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Live tags: squash hits older entries only, because the push below overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_r[i] <= '{live: 1'b0, rid: R0};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && (tag_r[i].rid == squash_reg)) begin
                    tag_r[i].live <= 1'b0;
                end
            end
            if (pop) begin
                tag_r[rd_ptr_r].live <= 1'b0;
            end
            if (push) begin
                tag_r[wr_ptr_r] <= '{live: 1'b1, rid: push_reg};
            end
        end
    end

    // Entry data storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= DATA_W'(0);
            end
        end else if (push) begin
            data_r[wr_ptr_r] <= push_data;
        end
    end

    // Query compare against live entries.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a = hit_a | (tag_r[i].live & (tag_r[i].rid == query_a));
            hit_b = hit_b | (tag_r[i].live & (tag_r[i].rid == query_b));
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file write port between writeback (always wins) and a
// queue of long-latency results that drains on idle writeback cycles.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   wb_valid/reg/data               writeback write, never back-pressured
//   ml_valid/reg/data, ml_ready     long-latency offer / queue has room
//   rs_id, rt_id, pend_rs, pend_rt  live queued write targets a source id
//   starve                          hazard unit must bubble writeback
//   rf_write_reg, rf_reg_id, rf_wdata   registered write port to the decoder
// -----------------------------------------------------------------------------
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ml_valid,
    input  logic [REG_W-1:0]  ml_reg,
    input  logic [DATA_W-1:0] ml_data,
    output logic              ml_ready,
    input  logic [REG_W-1:0]  rs_id,
    input  logic [REG_W-1:0]  rt_id,
    output logic              pend_rs,
    output logic              pend_rt,
    output logic              starve,
    output logic              rf_write_reg,
    output logic [REG_W-1:0]  rf_reg_id,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [SCNT_W-1:0] LIMIT_C  = SCNT_W'(STARVE_LIMIT);
    localparam logic [SCNT_W-1:0] SCNT_ONE = SCNT_W'(1);

    logic              head_live_s;
    logic [REG_W-1:0]  head_reg_s;
    logic [DATA_W-1:0] head_data_s;
    logic [CNT_W-1:0]  count_s;
    logic              hit_rs_s;
    logic              hit_rt_s;
    logic              head_valid_s;
    logic              push_s;
    logic              pop_s;
    logic              take_head_s;
    logic              squash_s;
    logic [SCNT_W-1:0] scnt_r;
    logic [SCNT_W-1:0] scnt_nxt_s;

    // Ready depends on count alone, so a full queue stays closed during a pop.
    assign ml_ready     = (count_s < DEPTH_C);
    assign push_s       = ml_valid & ml_ready;
    assign head_valid_s = (count_s != CNT_W'(0));
    assign squash_s     = wb_valid & (wb_reg != R0);
    assign pend_rs      = hit_rs_s & (rs_id != R0);
    assign pend_rt      = hit_rt_s & (rt_id != R0);

    rf_wr_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_reg   (ml_reg),
        .push_data  (ml_data),
        .pop        (pop_s),
        .squash_en  (squash_s),
        .squash_reg (wb_reg),
        .query_a    (rs_id),
        .query_b    (rt_id),
        .head_live  (head_live_s),
        .head_reg   (head_reg_s),
        .head_data  (head_data_s),
        .count      (count_s),
        .hit_a      (hit_rs_s),
        .hit_b      (hit_rt_s)
    );

    // Pop choice: a dead head always leaves; a live head leaves only when writeback is idle.
    always_comb begin
        pop_s       = 1'b0;
        take_head_s = 1'b0;
        if (head_valid_s) begin
            pop_s       = ~head_live_s | ~wb_valid;
            take_head_s = head_live_s & ~wb_valid;
        end else begin
            pop_s       = 1'b0;
            take_head_s = 1'b0;
        end
    end

    // Next starvation count: blocked live head counts up, any pop or empty queue clears.
    always_comb begin
        scnt_nxt_s = scnt_r;
        if (pop_s || !head_valid_s) begin
            scnt_nxt_s = SCNT_W'(0);
        end else if (head_live_s && wb_valid && (scnt_r != LIMIT_C)) begin
            scnt_nxt_s = scnt_r + SCNT_ONE;
        end else begin
            scnt_nxt_s = scnt_r;
        end
    end

    // Starvation counter and its registered flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt_r <= SCNT_W'(0);
            starve <= 1'b0;
        end else begin
            scnt_r <= scnt_nxt_s;
            starve <= (scnt_nxt_s == LIMIT_C);
        end
    end

    // Write port register: id/data hold when nothing is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write_reg <= 1'b0;
            rf_reg_id    <= R0;
            rf_wdata     <= DATA_W'(0);
        end else if (wb_valid) begin
            rf_write_reg <= (wb_reg != R0);
            rf_reg_id    <= wb_reg;
            rf_wdata     <= wb_data;
        end else if (take_head_s) begin
            rf_write_reg <= (head_reg_s != R0);
            rf_reg_id    <= head_reg_s;
            rf_wdata     <= head_data_s;
        end else begin
            rf_write_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a queue-level model of the arbiter.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 16;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid;
    logic [3:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              ml_valid;
    logic [3:0]        ml_reg;
    logic [DATA_W-1:0] ml_data;
    logic              ml_ready;
    logic [3:0]        rs_id;
    logic [3:0]        rt_id;
    logic              pend_rs;
    logic              pend_rt;
    logic              starve;
    logic              rf_write_reg;
    logic [3:0]        rf_reg_id;
    logic [DATA_W-1:0] rf_wdata;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        bit        live;
        bit [3:0]  r;
        bit [15:0] d;
    } ent_t;

    ent_t      mq[$];
    bit        m_we;
    bit [3:0]  m_id;
    bit [15:0] m_data;
    int        m_scnt;
    bit        m_starve;

    rf_write_arbiter #(
        .DEPTH        (DEPTH),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .ml_valid     (ml_valid),
        .ml_reg       (ml_reg),
        .ml_data      (ml_data),
        .ml_ready     (ml_ready),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .pend_rs      (pend_rs),
        .pend_rt      (pend_rt),
        .starve       (starve),
        .rf_write_reg (rf_write_reg),
        .rf_reg_id    (rf_reg_id),
        .rf_wdata     (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_pend(input bit [3:0] id);
        bit hit;
        hit = 1'b0;
        if (id != 4'd0) begin
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].r == id) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0; m_id = 4'd0; m_data = 16'd0; m_scnt = 0; m_starve = 1'b0;
    endtask

    // One clock edge of the model, evaluated from the inputs present at that edge.
    task automatic model_step();
        bit   accept, popped, popped_live, head_live;
        int   pre;
        ent_t h;
        if (rst) begin
            model_reset();
            return;
        end
        pre         = mq.size();
        accept      = ml_valid && (pre < DEPTH);
        popped      = 1'b0;
        popped_live = 1'b0;
        head_live   = (pre > 0) ? mq[0].live : 1'b0;
        if (pre > 0) begin
            if (!mq[0].live) begin
                mq.delete(0);
                popped = 1'b1;
            end else if (!wb_valid) begin
                h = mq.pop_front();
                popped = 1'b1;
                popped_live = 1'b1;
            end
        end
        if (popped || pre == 0) m_scnt = 0;
        else if (wb_valid && head_live && m_scnt < LIMIT) m_scnt++;
        m_starve = (m_scnt == LIMIT);
        if (wb_valid) begin
            m_we = (wb_reg != 4'd0); m_id = wb_reg; m_data = wb_data;
        end else if (popped_live) begin
            m_we = (h.r != 4'd0); m_id = h.r; m_data = h.d;
        end else begin
            m_we = 1'b0;
        end
        if (wb_valid && wb_reg != 4'd0) begin
            foreach (mq[i]) begin
                if (mq[i].r == wb_reg) mq[i].live = 1'b0;
            end
        end
        if (accept) mq.push_back('{1'b1, ml_reg, ml_data});
    endtask

    task automatic check_comb();
        chk("ml_ready", ml_ready, (mq.size() < DEPTH));
        chk("pend_rs", pend_rs, m_pend(rs_id));
        chk("pend_rt", pend_rt, m_pend(rt_id));
    endtask

    // The single compare point against the model.
    task automatic check_all();
        check_comb();
        chk("rf_write_reg", rf_write_reg, m_we);
        chk("rf_reg_id", rf_reg_id, m_id);
        chk("rf_wdata", rf_wdata, m_data);
        chk("starve", starve, m_starve);
    endtask

    // Inputs are set at the falling edge before calling; returns at the next falling edge.
    task automatic tick();
        if (rst) model_reset();
        #1 check_comb();
        @(posedge clk);
        model_step();
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic set_wb(input bit v, input bit [3:0] r, input bit [15:0] d);
        wb_valid = v; wb_reg = r; wb_data = d;
    endtask

    task automatic set_ml(input bit v, input bit [3:0] r, input bit [15:0] d);
        ml_valid = v; ml_reg = r; ml_data = d;
    endtask

    initial begin
        rst = 1'b1;
        set_wb(1'b0, 4'd0, 16'd0);
        set_ml(1'b0, 4'd0, 16'd0);
        rs_id = 4'd0; rt_id = 4'd0;
        @(negedge clk);
        tick(); tick();
        chk("reset_we", rf_write_reg, 1'b0);
        chk("reset_ready", ml_ready, 1'b1);
        chk("reset_starve", starve, 1'b0);
        rst = 1'b0;

        // Writeback only.
        set_wb(1'b1, 4'd5, 16'h1234); tick();
        chk("wb_we", rf_write_reg, 1'b1);
        chk("wb_id", rf_reg_id, 4'd5);
        chk("wb_data", rf_wdata, 16'h1234);

        // Conflict and back-pressure.
        set_wb(1'b1, 4'd1, 16'h0001); set_ml(1'b1, 4'd7, 16'hBEEF); tick();
        set_wb(1'b1, 4'd2, 16'h0002); set_ml(1'b1, 4'd8, 16'hCAFE); tick();
        chk("bp_ready", ml_ready, 1'b0);
        set_wb(1'b1, 4'd3, 16'h0003); set_ml(1'b0, 4'd0, 16'd0); tick();
        set_wb(1'b0, 4'd0, 16'd0); tick();
        chk("drain1_id", rf_reg_id, 4'd7);
        chk("drain1_data", rf_wdata, 16'hBEEF);
        chk("drain1_we", rf_write_reg, 1'b1);
        tick();
        chk("drain2_id", rf_reg_id, 4'd8);
        chk("drain2_data", rf_wdata, 16'hCAFE);
        tick();
        chk("drain_idle_we", rf_write_reg, 1'b0);

        // Squash.
        rs_id = 4'd9;
        set_ml(1'b1, 4'd9, 16'hAAAA); tick();
        chk("sq_pend_before", pend_rs, 1'b1);
        set_ml(1'b0, 4'd0, 16'd0); set_wb(1'b1, 4'd9, 16'h5555); tick();
        chk("sq_pend_after", pend_rs, 1'b0);
        chk("sq_data", rf_wdata, 16'h5555);
        set_wb(1'b0, 4'd0, 16'd0); tick();
        chk("sq_dead_we", rf_write_reg, 1'b0);
        chk("sq_dead_ready", ml_ready, 1'b1);

        // R0.
        rs_id = 4'd0;
        set_wb(1'b1, 4'd0, 16'h0F0F); set_ml(1'b1, 4'd0, 16'h1111); tick();
        chk("r0_wb_we", rf_write_reg, 1'b0);
        set_wb(1'b0, 4'd0, 16'd0); set_ml(1'b0, 4'd0, 16'd0); tick();
        chk("r0_ml_we", rf_write_reg, 1'b0);
        chk("r0_popped", ml_ready, 1'b1);

        // Starve.
        set_ml(1'b1, 4'd3, 16'h3333); tick();
        set_ml(1'b0, 4'd0, 16'd0);
        set_wb(1'b1, 4'd4, 16'h4444);
        tick(); tick(); tick();
        chk("starve_3", starve, 1'b0);
        tick();
        chk("starve_4", starve, 1'b1);
        set_wb(1'b0, 4'd0, 16'd0); tick();
        chk("starve_clear", starve, 1'b0);
        chk("starve_drain_id", rf_reg_id, 4'd3);

        // Reset mid-traffic with two entries queued.
        rs_id = 4'd10; rt_id = 4'd11;
        set_wb(1'b1, 4'd1, 16'h0101); set_ml(1'b1, 4'd10, 16'hA0A0); tick();
        set_wb(1'b1, 4'd1, 16'h0102); set_ml(1'b1, 4'd11, 16'hB0B0); tick();
        chk("pre_rst_pend", pend_rt, 1'b1);
        rst = 1'b1;
        set_wb(1'b0, 4'd0, 16'd0); set_ml(1'b0, 4'd0, 16'd0); tick();
        chk("mid_rst_we", rf_write_reg, 1'b0);
        chk("mid_rst_id", rf_reg_id, 4'd0);
        chk("mid_rst_data", rf_wdata, 16'd0);
        chk("mid_rst_ready", ml_ready, 1'b1);
        chk("mid_rst_pend", pend_rs, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_no_write", rf_write_reg, 1'b0);
        end

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            set_wb((n < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0),
                   4'($urandom_range(0, 4)), 16'($urandom));
            set_ml($urandom_range(0, 1) == 1, 4'($urandom_range(0, 4)), 16'($urandom));
            rs_id = 4'($urandom_range(0, 4));
            rt_id = 4'($urandom_range(0, 4));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
